// File: rtl/dtmf_pkg.sv
// Shared types and constants for the DTMF digit collector.
package dtmf_pkg;

    localparam int KEY_W          = 4;
    localparam int TONE_VALID_BIT = 4;
    localparam int STAMP_W        = 16;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CANDIDATE = 2'd1,
        HELD      = 2'd2
    } state_t;

    localparam logic [KEY_W-1:0] KEY_0    = 4'h0;
    localparam logic [KEY_W-1:0] KEY_9    = 4'h9;
    localparam logic [KEY_W-1:0] KEY_STAR = 4'hA;
    localparam logic [KEY_W-1:0] KEY_HASH = 4'hB;
    localparam logic [KEY_W-1:0] KEY_A    = 4'hC;
    localparam logic [KEY_W-1:0] KEY_B    = 4'hD;
    localparam logic [KEY_W-1:0] KEY_C    = 4'hE;
    localparam logic [KEY_W-1:0] KEY_D    = 4'hF;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dtmf_digit_fifo.sv
// Synchronous digit FIFO; a push into a full FIFO succeeds only alongside a pop.
module dtmf_digit_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // DEPTH is a power of two, so the count MSB alone marks full.
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign valid   = ~empty;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dtmf_digit_collector.sv
// Debounces per-frame DTMF key codes and queues each press once.
// Optional DTMF_TIMESTAMP_EN adds a frame-count stamp per digit.
module dtmf_digit_collector
    import dtmf_pkg::*;
#(
    parameter int CONFIRM_FRAMES = 3,
    parameter int GAP_FRAMES     = 2,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frame_done,
    input  logic [15:0]                   tone_in,
    output logic                          digit_valid,
    input  logic                          digit_ready,
    output logic [3:0]                    digit_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic                          key_held
`ifdef DTMF_TIMESTAMP_EN
    ,
    output logic [15:0]                   digit_stamp
`endif
);

`ifdef DTMF_TIMESTAMP_EN
    localparam int DW = KEY_W + STAMP_W;
`else
    localparam int DW = KEY_W;
`endif
    localparam logic [CNT_W-1:0] CONF_N = CNT_W'(CONFIRM_FRAMES);
    localparam logic [CNT_W-1:0] GAP_N  = CNT_W'(GAP_FRAMES);

    state_t           state;
    state_t           state_nx;
    logic [KEY_W-1:0] cand_key;
    logic [KEY_W-1:0] cand_nx;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] match_nx;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_nx;
    logic             emit_q;
    logic             emit_nx;
    logic [KEY_W-1:0] emit_key;
    logic             new_key;

    logic             tone_valid;
    logic [KEY_W-1:0] tone_key;
    logic             unused_tone_bits;

    logic [DW-1:0]    push_data;
    logic [DW-1:0]    head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;

    assign tone_valid       = tone_in[TONE_VALID_BIT];
    assign tone_key         = tone_in[KEY_W-1:0];
    assign unused_tone_bits = ^tone_in[15:5];
    assign key_held         = (state == HELD);

    always_comb begin
        state_nx = state;
        cand_nx  = cand_key;
        match_nx = match_cnt;
        gap_nx   = gap_cnt;
        emit_nx  = 1'b0;
        new_key  = 1'b0;
        if (frame_done) begin
            unique case (state)
                IDLE: begin
                    new_key = tone_valid;
                end
                CANDIDATE: begin
                    if (!tone_valid) begin
                        state_nx = IDLE;
                        match_nx = '0;
                    end else if (tone_key == cand_key) begin
                        match_nx = sat_inc(match_cnt);
                        if (match_nx >= CONF_N) begin
                            state_nx = HELD;
                            emit_nx  = 1'b1;
                            gap_nx   = '0;
                        end
                    end else begin
                        new_key = 1'b1;
                    end
                end
                HELD: begin
                    if (!tone_valid) begin
                        gap_nx = sat_inc(gap_cnt);
                        if (gap_nx >= GAP_N) begin
                            state_nx = IDLE;
                            gap_nx   = '0;
                            match_nx = '0;
                        end
                    end else if (tone_key == cand_key) begin
                        gap_nx = '0;
                    end else begin
                        new_key = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
        // A fresh key always restarts the debounce, even from HELD.
        if (new_key) begin
            cand_nx  = tone_key;
            match_nx = CNT_W'(1);
            gap_nx   = '0;
            if (CONF_N <= CNT_W'(1)) begin
                state_nx = HELD;
                emit_nx  = 1'b1;
            end else begin
                state_nx = CANDIDATE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cand_key  <= '0;
            match_cnt <= '0;
            gap_cnt   <= '0;
            emit_q    <= 1'b0;
            emit_key  <= '0;
        end else begin
            state     <= state_nx;
            cand_key  <= cand_nx;
            match_cnt <= match_nx;
            gap_cnt   <= gap_nx;
            emit_q    <= emit_nx;
            if (emit_nx) begin
                emit_key <= cand_nx;
            end
        end
    end

`ifdef DTMF_TIMESTAMP_EN
    logic [STAMP_W-1:0] frame_cnt;
    logic [STAMP_W-1:0] emit_stamp;

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt  <= '0;
            emit_stamp <= '0;
        end else begin
            if (frame_done) begin
                frame_cnt <= frame_cnt + STAMP_W'(1);
            end
            if (emit_nx) begin
                emit_stamp <= frame_cnt;
            end
        end
    end

    assign push_data   = {emit_stamp, emit_key};
    assign digit_stamp = head[DW-1:KEY_W];
`else
    assign push_data = emit_key;
`endif

    assign digit_out = head[KEY_W-1:0];

    dtmf_digit_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (emit_q),
        .push_data (push_data),
        .pop       (digit_ready),
        .rd_data   (head),
        .valid     (digit_valid),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign drop = emit_q & fifo_full & ~(digit_ready & ~fifo_empty);

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dtmf_digit_collector.sv
// Directed self-checking bench for dtmf_digit_collector.
module tb_dtmf_digit_collector;

    logic        clock;
    logic        reset;
    logic        frame_done;
    logic [15:0] tone_in;
    logic        digit_valid;
    logic        digit_ready;
    logic [3:0]  digit_out;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        clear_overflow;
    logic        key_held;
`ifdef DTMF_TIMESTAMP_EN
    logic [15:0] digit_stamp;
`endif

    int checks   = 0;
    int failures = 0;

    dtmf_digit_collector dut (
        .clock          (clock),
        .reset          (reset),
        .frame_done     (frame_done),
        .tone_in        (tone_in),
        .digit_valid    (digit_valid),
        .digit_ready    (digit_ready),
        .digit_out      (digit_out),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .key_held       (key_held)
`ifdef DTMF_TIMESTAMP_EN
        ,
        .digit_stamp    (digit_stamp)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One frame_done pulse; junk in the ignored upper bits.
    task automatic frame(input logic v, input logic [3:0] k);
        @(negedge clock);
        frame_done = 1'b1;
        tone_in    = {11'h5A5, v, k};
        @(negedge clock);
        frame_done = 1'b0;
        tone_in    = 16'h0;
    endtask

    task automatic press(input logic [3:0] k);
        repeat (3) frame(1'b1, k);
        repeat (2) frame(1'b0, 4'h0);
    endtask

    task automatic pop_chk(input string tag, input logic [3:0] k);
        chk({tag, "_valid"}, 32'(digit_valid), 32'd1);
        chk({tag, "_digit"}, 32'(digit_out), 32'(k));
        digit_ready = 1'b1;
        @(negedge clock);
        digit_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        frame_done     = 1'b0;
        tone_in        = 16'h0;
        digit_ready    = 1'b0;
        clear_overflow = 1'b0;
        tick(3);
        chk("rst_valid", 32'(digit_valid), 32'd0);
        chk("rst_digit", 32'(digit_out), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
        reset = 1'b0;

        // Key 5: confirm on third frame, digit visible two cycles later
        frame(1'b1, 4'h5);
        frame(1'b1, 4'h5);
        chk("k5_held_early", 32'(key_held), 32'd0);
        frame(1'b1, 4'h5);
        chk("k5_held", 32'(key_held), 32'd1);
        chk("k5_valid_1cyc", 32'(digit_valid), 32'd0);
        tick(1);
        chk("k5_valid_2cyc", 32'(digit_valid), 32'd1);
        chk("k5_count", 32'(fifo_count), 32'd1);
        frame(1'b0, 4'h0);
        chk("k5_gap1_held", 32'(key_held), 32'd1);
        frame(1'b0, 4'h0);
        chk("k5_gap2_idle", 32'(key_held), 32'd0);
        chk("k5_count_end", 32'(fifo_count), 32'd1);
        pop_chk("k5_pop", 4'h5);
        chk("k5_empty", 32'(fifo_count), 32'd0);

        // Key 7 held 20 frames: one emit
        for (int i = 0; i < 20; i++) begin
            frame(1'b1, 4'h7);
            if (i >= 2) chk("k7_held", 32'(key_held), 32'd1);
        end
        chk("k7_count", 32'(fifo_count), 32'd1);
        repeat (2) frame(1'b0, 4'h0);
        chk("k7_count_rel", 32'(fifo_count), 32'd1);
        pop_chk("k7_pop", 4'h7);

        // 3,3,9,9,9 emits only 9
        frame(1'b1, 4'h3);
        frame(1'b1, 4'h3);
        repeat (3) frame(1'b1, 4'h9);
        repeat (2) frame(1'b0, 4'h0);
        chk("k39_count", 32'(fifo_count), 32'd1);
        pop_chk("k39_pop", 4'h9);

        // 3,3,none,3 emits nothing
        frame(1'b1, 4'h3);
        frame(1'b1, 4'h3);
        frame(1'b0, 4'h0);
        frame(1'b1, 4'h3);
        tick(3);
        chk("k3n3_count", 32'(fifo_count), 32'd0);
        chk("k3n3_held", 32'(key_held), 32'd0);

        // Ready on empty FIFO is ignored
        digit_ready = 1'b1;
        tick(1);
        digit_ready = 1'b0;
        chk("empty_pop_count", 32'(fifo_count), 32'd0);
        chk("empty_pop_valid", 32'(digit_valid), 32'd0);

        // 17 presses without ready: last one dropped
        for (int i = 0; i < 17; i++) press(4'(i));
        chk("full_count", 32'(fifo_count), 32'd16);
        chk("full_ovf", 32'(overflow), 32'd1);
        chk("full_head", 32'(digit_out), 32'd0);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Push and pop together while full
        repeat (3) frame(1'b1, 4'hC);
        digit_ready = 1'b1;
        tick(1);
        digit_ready = 1'b0;
        chk("pp_count", 32'(fifo_count), 32'd16);
        chk("pp_ovf", 32'(overflow), 32'd0);
        repeat (2) frame(1'b0, 4'h0);
        chk("pp_ovf_late", 32'(overflow), 32'd0);

        for (int i = 1; i < 16; i++) pop_chk("drain", 4'(i));
        pop_chk("drain_last", 4'hC);
        chk("drain_count", 32'(fifo_count), 32'd0);
        chk("drain_valid", 32'(digit_valid), 32'd0);

        // Reset mid-candidate with a digit buffered
        press(4'h2);
        chk("pre_rst_count", 32'(fifo_count), 32'd1);
        frame(1'b1, 4'h4);
        frame(1'b1, 4'h4);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_valid", 32'(digit_valid), 32'd0);
        chk("mid_rst_digit", 32'(digit_out), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_held", 32'(key_held), 32'd0);
        reset = 1'b0;
        frame(1'b1, 4'h4);
        tick(3);
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        frame(1'b1, 4'h4);
        tick(3);
        chk("post_rst_count2", 32'(fifo_count), 32'd0);
        chk("post_rst_held", 32'(key_held), 32'd0);

`ifdef DTMF_TIMESTAMP_EN
        do_reset();
        chk("stamp_rst", 32'(digit_stamp), 32'd0);
        repeat (3) frame(1'b0, 4'h0);
        repeat (3) frame(1'b1, 4'h8);
        tick(2);
        chk("stamp_digit", 32'(digit_out), 32'd8);
        chk("stamp_val", 32'(digit_stamp), 32'd5);
`else
        do_reset();
        chk("final_rst_count", 32'(fifo_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
